pixel_histogram: RTL and testbench
==================================

PIXEL_HISTOGRAM -- requirements
Module: pixel_histogram

Interface
REQ-001 Parameter CNT_W, default 16, bin counter width in bits; legal values 4..24.
REQ-002 Parameter TOT_W, default 24, frame pixel-total counter width in bits.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 start  input  1  one-cycle request to clear all bins and begin a frame.
REQ-006 in_valid  input  1  inbyte carries a pixel this cycle.
REQ-007 inbyte  input  8  pixel value from the point-operation stage (its outbyte).
REQ-008 frame_end  input  1  one-cycle marker: last pixel of the frame has been presented.
REQ-009 in_ready  output  1  block is accepting pixels.
REQ-010 out_valid  output  1  out_bin and out_count hold a valid histogram entry.
REQ-011 out_ready  input  1  downstream accepts the current entry.
REQ-012 out_bin  output  8  bin index of the current entry.
REQ-013 out_count  output  CNT_W  pixel count of the current bin.
REQ-014 pixel_total  output  TOT_W  pixels counted in the current or last frame, saturating.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse after bin 255 is accepted.

Function
REQ-017 The FSM SHALL have states IDLE, CLEAR, ACCUM, DRAIN and DUMP.
REQ-018 In IDLE, start=1 SHALL move the FSM to CLEAR; start SHALL be ignored in all other states.
REQ-019 CLEAR SHALL zero one bin per cycle, bins 0 to 255 in order, SHALL zero pixel_total, and SHALL enter ACCUM after exactly 256 cycles.
REQ-020 in_ready SHALL be 1 only in ACCUM; pixels with in_valid=1 in any other state SHALL be ignored.
REQ-021 In ACCUM, each cycle with in_valid=1 SHALL add 1 to bin[inbyte] and to pixel_total, each saturating at its all-ones value.
REQ-022 Bin updates SHALL use an internal read-modify-write pipeline with forwarding, so that back-to-back or interleaved repeats of a value are all counted; no pixel may be lost.
REQ-023 frame_end in ACCUM SHALL move the FSM to DRAIN; a pixel with in_valid=1 in the same cycle SHALL be counted.
REQ-024 DRAIN SHALL last until all pending bin writes have committed, at most 2 cycles, and SHALL then enter DUMP with out_bin=0.
REQ-025 In DUMP, out_valid SHALL be 1 and out_count SHALL equal the final count of bin out_bin.
REQ-026 A transfer SHALL occur on each cycle with out_valid=1 and out_ready=1; out_bin SHALL then advance by 1.
REQ-027 While out_valid=1 and out_ready=0, out_bin and out_count SHALL hold stable.
REQ-028 The transfer of bin 255 SHALL return the FSM to IDLE, clear out_valid and pulse done for exactly one cycle.
REQ-029 pixel_total SHALL hold its final value through DUMP and IDLE until the next CLEAR.
REQ-030 frame_end outside ACCUM SHALL be ignored.
REQ-031 Bin storage SHALL be a 256 x CNT_W single-read, single-write memory.

Reset
REQ-032 With rst_n=0, the FSM SHALL be in IDLE, and in_ready, out_valid, out_bin, out_count, pixel_total, busy and done SHALL all be 0.
REQ-033 Reset asserted in any state, including mid-CLEAR, mid-ACCUM or mid-DUMP, SHALL abort the operation immediately.
REQ-034 Bin memory contents are not reset; only CLEAR initialises them.

Verification
REQ-035 Reset: assert rst_n=0 at any time -> all outputs 0 and busy=0 on the same cycle.
REQ-036 Basic frame: start -> in_ready rises 256 cycles later; present 4 back-to-back pixels of 0x10, then frame_end -> DUMP streams 256 entries with bin 0x10 = 4 and all others 0, pixel_total = 4, done pulses once.
REQ-037 Hazard pattern: pixels 0x00,0x01,0x00,0x00,0x01 back-to-back, with frame_end in the same cycle as the last pixel -> bin 0 = 3, bin 1 = 2, pixel_total = 5.
REQ-038 Saturation, CNT_W=4: 20 pixels of 0xFF -> bin 0xFF = 15, pixel_total = 20.
REQ-039 Backpressure: hold out_ready=0 for 5 cycles while out_bin=3 -> out_bin=3 and out_count unchanged throughout; the transfer completes on the first out_ready=1 cycle.
REQ-040 Illegal and abort cases: start during ACCUM -> no effect; in_valid during CLEAR -> not counted; rst_n=0 mid-DUMP -> out_valid=0 and FSM in IDLE.

Source files
------------

// File: rtl/pixel_histogram.sv
// Pixel histogram: counts 8-bit pixel values into 256 bins per frame.
// The bins are cleared one per cycle, then pixels are accumulated through a
// read-modify-write pipeline, then the 256 counts are streamed out with a
// valid/ready handshake. The bin store is a 256-entry memory with one
// synchronous read port and one write port.

module pixel_histogram #(
    parameter int CNT_W = 16,
    parameter int TOT_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic [7:0]       inbyte,
    input  logic             frame_end,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_bin,
    output logic [CNT_W-1:0] out_count,
    output logic [TOT_W-1:0] pixel_total,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLEAR = 3'd1;
    localparam logic [2:0] ST_ACCUM = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DUMP  = 3'd4;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [TOT_W-1:0] TOT_ONE = {{(TOT_W-1){1'b0}}, 1'b1};

    // Bin storage; never reset, only the CLEAR sweep initialises it.
    logic [CNT_W-1:0] mem [0:255];
    logic [CNT_W-1:0] rd_data_q;

    logic [2:0]       state_q, state_d;
    logic [7:0]       clr_q, clr_d;
    logic [7:0]       out_bin_q, out_bin_d;
    logic [TOT_W-1:0] tot_q, tot_d;
    logic             done_q, done_d;

    // Stage 1 of the bin update: pixel whose bin value is arriving from memory.
    logic             s1_valid_q, s1_valid_d;
    logic [7:0]       s1_addr_q, s1_addr_d;

    // Copy of the write committed on the same edge as the stage-1 read, used
    // to forward a value the memory read could not yet see.
    logic             wb_valid_q, wb_valid_d;
    logic [7:0]       wb_addr_q, wb_addr_d;
    logic [CNT_W-1:0] wb_data_q, wb_data_d;

    logic             accept;
    logic [7:0]       rd_addr;
    logic             wr_en;
    logic [7:0]       wr_addr;
    logic [CNT_W-1:0] wr_data;
    logic [CNT_W-1:0] cur_count;
    logic [CNT_W-1:0] inc_count;

    assign accept = (state_q == ST_ACCUM) && in_valid;

    // Control FSM: sequencing of clear, accumulate, drain and dump phases.
    always_comb begin
        state_d   = state_q;
        clr_d     = clr_q;
        out_bin_d = out_bin_q;
        tot_d     = tot_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CLEAR;
                    clr_d   = 8'd0;
                end
            end
            ST_CLEAR: begin
                tot_d = '0;
                clr_d = clr_q + 8'd1;
                if (clr_q == 8'hFF) begin
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (accept && (tot_q != {TOT_W{1'b1}})) begin
                    tot_d = tot_q + TOT_ONE;
                end
                if (frame_end) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                out_bin_d = 8'd0;
                if (!s1_valid_q) begin
                    state_d = ST_DUMP;
                end
            end
            ST_DUMP: begin
                if (out_ready) begin
                    out_bin_d = out_bin_q + 8'd1;
                    if (out_bin_q == 8'hFF) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Read-modify-write datapath: forwarded current count, saturating increment.
    always_comb begin
        s1_valid_d = accept;
        s1_addr_d  = inbyte;
        if (wb_valid_q && (wb_addr_q == s1_addr_q)) begin
            cur_count = wb_data_q;
        end else begin
            cur_count = rd_data_q;
        end
        if (cur_count == {CNT_W{1'b1}}) begin
            inc_count = cur_count;
        end else begin
            inc_count = cur_count + CNT_ONE;
        end
    end

    // Memory port steering: CLEAR sweep or pipeline commit on the write side,
    // incoming pixel, bin 0 prefetch or dump entry on the read side.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = 8'd0;
        wr_data = '0;
        if (state_q == ST_CLEAR) begin
            wr_en   = 1'b1;
            wr_addr = clr_q;
            wr_data = '0;
        end else if (s1_valid_q) begin
            wr_en   = 1'b1;
            wr_addr = s1_addr_q;
            wr_data = inc_count;
        end
        wb_valid_d = wr_en;
        wb_addr_d  = wr_addr;
        wb_data_d  = wr_data;

        rd_addr = 8'd0;
        case (state_q)
            ST_ACCUM: rd_addr = inbyte;
            ST_DUMP:  rd_addr = out_ready ? (out_bin_q + 8'd1) : out_bin_q;
            default:  rd_addr = 8'd0;
        endcase
    end

    // Bin memory: one write and one registered read per cycle.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_q <= mem[rd_addr];
    end

    // Control and pipeline registers, cleared immediately by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            clr_q      <= 8'd0;
            out_bin_q  <= 8'd0;
            tot_q      <= '0;
            done_q     <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_addr_q  <= 8'd0;
            wb_valid_q <= 1'b0;
            wb_addr_q  <= 8'd0;
            wb_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            clr_q      <= clr_d;
            out_bin_q  <= out_bin_d;
            tot_q      <= tot_d;
            done_q     <= done_d;
            s1_valid_q <= s1_valid_d;
            s1_addr_q  <= s1_addr_d;
            wb_valid_q <= wb_valid_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
        end
    end

    assign in_ready    = (state_q == ST_ACCUM);
    assign out_valid   = (state_q == ST_DUMP);
    assign out_bin     = out_bin_q;
    assign out_count   = out_valid ? rd_data_q : '0;
    assign pixel_total = tot_q;
    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;

endmodule

// File: tb/tb_pixel_histogram.sv
// Testbench for pixel_histogram: two instances (16-bit and 4-bit bins) share
// one stimulus stream; frames come from a table of hand-computed vectors,
// plus directed reset, abort and backpressure sequences.

module tb_pixel_histogram;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic [7:0]  inbyte;
    logic        frame_end;
    logic        out_ready;

    logic        inReady16, outValid16, busy16, done16;
    logic [7:0]  outBin16;
    logic [15:0] outCount16;
    logic [23:0] pixelTotal16;

    logic        inReady4, outValid4, busy4, done4;
    logic [7:0]  outBin4;
    logic [3:0]  outCount4;
    logic [23:0] pixelTotal4;

    int vecCount;
    int missCount;

    typedef struct packed {
        logic [5:0][7:0] pat;
        int              plen;
        int              reps;
        bit              gap;
        bit              feLast;
        logic [7:0]      binA;
        int              expA16;
        int              expA4;
        logic [7:0]      binB;
        int              expB16;
        int              expB4;
        int              expTotal;
        bit              stall;
    } vec_t;

    vec_t vecs [5];

    pixel_histogram #(.CNT_W(16), .TOT_W(24)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .inbyte(inbyte), .frame_end(frame_end), .in_ready(inReady16),
        .out_valid(outValid16), .out_ready(out_ready), .out_bin(outBin16),
        .out_count(outCount16), .pixel_total(pixelTotal16), .busy(busy16),
        .done(done16)
    );

    pixel_histogram #(.CNT_W(4), .TOT_W(24)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .inbyte(inbyte), .frame_end(frame_end), .in_ready(inReady4),
        .out_valid(outValid4), .out_ready(out_ready), .out_bin(outBin4),
        .out_count(outCount4), .pixel_total(pixelTotal4), .busy(busy4),
        .done(done4)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute time limit so a stuck design still terminates.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Start a frame and wait out the 256-cycle clear while driving pixels,
    // frame_end and start that must all be ignored.
    task automatic startFrame(input int v);
        int cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        while (!inReady16 && cnt < 400) begin
            cnt++;
            if (cnt < 250) begin
                start     = 1'b1;
                in_valid  = 1'b1;
                inbyte    = vecs[v].pat[0];
                frame_end = 1'b1;
            end else begin
                start     = 1'b0;
                in_valid  = 1'b0;
                frame_end = 1'b0;
            end
            @(negedge clk);
        end
        start     = 1'b0;
        in_valid  = 1'b0;
        frame_end = 1'b0;
        checkOutput("clearLatency", cnt, 256);
        checkOutput("inReady4", inReady4, 1);
        checkOutput("totalCleared", pixelTotal16, 0);
    endtask

    // Present the vector's pixels; a start pulse on the second pixel must be ignored.
    task automatic feedPixels(input int v);
        int idx;
        idx = 0;
        for (int r = 0; r < vecs[v].reps; r++) begin
            for (int i = 0; i < vecs[v].plen; i++) begin
                inbyte    = vecs[v].pat[i];
                in_valid  = 1'b1;
                start     = (idx == 1);
                frame_end = vecs[v].feLast && (r == vecs[v].reps - 1) && (i == vecs[v].plen - 1);
                idx++;
                @(negedge clk);
                if (vecs[v].gap) begin
                    in_valid  = 1'b0;
                    start     = 1'b0;
                    frame_end = 1'b0;
                    @(negedge clk);
                end
            end
        end
        in_valid  = 1'b0;
        start     = 1'b0;
        frame_end = 1'b0;
        if (!vecs[v].feLast) begin
            frame_end = 1'b1;
            @(negedge clk);
            frame_end = 1'b0;
        end
    endtask

    // Wait for the dump to begin; drain may take one or two cycles.
    task automatic waitDrain();
        int n;
        n = 0;
        while (!outValid16 && n < 10) begin
            n++;
            @(negedge clk);
        end
        checkOutput("drainCycles1to2", (n >= 1 && n <= 2), 1);
        checkOutput("dumpFirstBin", outBin16, 0);
    endtask

    // Stream all 256 entries and compare each against the vector's expectations.
    task automatic dumpCheck(input int v, input bit stall);
        int exp16;
        int exp4;
        out_ready = 1'b1;
        checkOutput("dumpTotal16", pixelTotal16, vecs[v].expTotal);
        for (int k = 0; k < 256; k++) begin
            if (k == vecs[v].binA) begin
                exp16 = vecs[v].expA16;
                exp4  = vecs[v].expA4;
            end else if (k == vecs[v].binB) begin
                exp16 = vecs[v].expB16;
                exp4  = vecs[v].expB4;
            end else begin
                exp16 = 0;
                exp4  = 0;
            end
            checkOutput($sformatf("v%0d outValid bin%0d", v, k), outValid16, 1);
            checkOutput($sformatf("v%0d outBin idx%0d", v, k), outBin16, k);
            checkOutput($sformatf("v%0d count16 bin%0d", v, k), outCount16, exp16);
            checkOutput($sformatf("v%0d count4 bin%0d", v, k), outCount4, exp4);
            if (stall && k == 3) begin
                out_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    checkOutput($sformatf("stall%0d outBin", s), outBin16, 3);
                    checkOutput($sformatf("stall%0d count16", s), outCount16, exp16);
                    checkOutput($sformatf("stall%0d outValid", s), outValid16, 1);
                end
                out_ready = 1'b1;
            end
            @(negedge clk);
        end
        checkOutput("doneAfterLast16", done16, 1);
        checkOutput("doneAfterLast4", done4, 1);
        checkOutput("outValidAfterLast", outValid16, 0);
        checkOutput("idleBusy", busy16, 0);
        checkOutput("finalTotal16", pixelTotal16, vecs[v].expTotal);
        checkOutput("finalTotal4", pixelTotal4, vecs[v].expTotal);
        out_ready = 1'b0;
        @(negedge clk);
        checkOutput("donePulseOnce", done16, 0);
        checkOutput("totalHeldIdle", pixelTotal16, vecs[v].expTotal);
    endtask

    task automatic applyStimulus(input int v, input bit stall);
        startFrame(v);
        feedPixels(v);
        waitDrain();
        dumpCheck(v, stall);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " inReady16"}, inReady16, 0);
        checkOutput({tag, " outValid16"}, outValid16, 0);
        checkOutput({tag, " outBin16"}, outBin16, 0);
        checkOutput({tag, " outCount16"}, outCount16, 0);
        checkOutput({tag, " pixelTotal16"}, pixelTotal16, 0);
        checkOutput({tag, " busy16"}, busy16, 0);
        checkOutput({tag, " done16"}, done16, 0);
        checkOutput({tag, " outValid4"}, outValid4, 0);
        checkOutput({tag, " outCount4"}, outCount4, 0);
        checkOutput({tag, " busy4"}, busy4, 0);
    endtask

    initial begin
        vecCount  = 0;
        missCount = 0;

        // Basic: four back-to-back 0x10 pixels, frame_end afterwards, backpressure at bin 3.
        vecs[0] = '{pat: {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10}, plen: 1, reps: 4,
                    gap: 1'b0, feLast: 1'b0, binA: 8'h10, expA16: 4, expA4: 4,
                    binB: 8'h00, expB16: 0, expB4: 0, expTotal: 4, stall: 1'b1};
        // Hazard: 00,01,00,00,01 back-to-back, frame_end with the last pixel.
        vecs[1] = '{pat: {8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00}, plen: 5, reps: 1,
                    gap: 1'b0, feLast: 1'b1, binA: 8'h00, expA16: 3, expA4: 3,
                    binB: 8'h01, expB16: 2, expB4: 2, expTotal: 5, stall: 1'b0};
        // Saturation: twenty 0xFF pixels; the 4-bit bin stops at 15.
        vecs[2] = '{pat: {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF}, plen: 1, reps: 20,
                    gap: 1'b0, feLast: 1'b0, binA: 8'hFF, expA16: 20, expA4: 15,
                    binB: 8'h00, expB16: 0, expB4: 0, expTotal: 20, stall: 1'b0};
        // Interleaved with idle gaps: 05,07,05 three times.
        vecs[3] = '{pat: {8'h00, 8'h00, 8'h00, 8'h05, 8'h07, 8'h05}, plen: 3, reps: 3,
                    gap: 1'b1, feLast: 1'b0, binA: 8'h05, expA16: 6, expA4: 6,
                    binB: 8'h07, expB16: 3, expB4: 3, expTotal: 9, stall: 1'b0};
        // Mixed distances: 20,21,21,20,20 twice, frame_end with the last pixel.
        vecs[4] = '{pat: {8'h00, 8'h20, 8'h20, 8'h21, 8'h21, 8'h20}, plen: 5, reps: 2,
                    gap: 1'b0, feLast: 1'b1, binA: 8'h20, expA16: 6, expA4: 6,
                    binB: 8'h21, expB16: 4, expB4: 4, expTotal: 10, stall: 1'b0};

        rst_n     = 1'b0;
        start     = 1'b1;
        in_valid  = 1'b1;
        inbyte    = 8'h10;
        frame_end = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checkAllZero("reset");

        start     = 1'b0;
        in_valid  = 1'b0;
        frame_end = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);

        frame_end = 1'b1;
        in_valid  = 1'b1;
        @(negedge clk);
        frame_end = 1'b0;
        in_valid  = 1'b0;
        checkOutput("idleFrameEndIgnored", busy16, 0);
        checkOutput("idleInReady", inReady16, 0);

        for (int v = 0; v < 5; v++) begin
            $display("[TB] frame vector %0d", v);
            applyStimulus(v, vecs[v].stall);
        end

        $display("[TB] reset during dump");
        startFrame(0);
        feedPixels(0);
        waitDrain();
        out_ready = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("midDumpBin", outBin16, 10);
        rst_n = 1'b0;
        #1;
        checkAllZero("abortDump");
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        checkOutput("afterAbortIdle", busy16, 0);

        $display("[TB] frame after abort");
        applyStimulus(1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
